fsm_ascon: RTL and testbench

Sequencing controller for the ASCON-128 encryption datapath. Drives the permutation state register, the round counter and the external block counter through initialisation, associated-data absorption, plaintext encryption and finalisation. Emits the data-capture strobes that load ciphertext and tag. Sits between the top-level handshake (start/data valid) and the permutation/XOR datapath.

---
 rtl/ascon_pack.sv | 20 ++
 rtl/compteur_double_init.sv | 39 +++
 rtl/fsm_ascon.sv | 175 +++++++++++++++++
 tb/tb_fsm_ascon.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON-128 sequencing controller.
// Holds the FSM state enum and the round counter load/limit values.
package ascon_pack;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD,
        S_PT_WAIT,
        S_PT,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] ROUND_INIT_A = 4'd0;
    localparam logic [3:0] ROUND_INIT_B = 4'd6;
    localparam logic [3:0] ROUND_LAST   = 4'd11;

endpackage

// File: rtl/compteur_double_init.sv
// 4-bit round counter with two synchronous load values and an enable.
// Ports: clock_i, resetb_i (async low), init_a_i, init_b_i, en_i, cnt_o.
module compteur_double_init
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       init_a_i,
    input  logic       init_b_i,
    input  logic       en_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Saturates at the last round so WAIT states hold a stable index.
    always_comb begin
        cnt_d = cnt_q;
        if (init_a_i) begin
            cnt_d = ROUND_INIT_A;
        end else if (init_b_i) begin
            cnt_d = ROUND_INIT_B;
        end else if (en_i && (cnt_q != ROUND_LAST)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= ROUND_INIT_A;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_ascon.sv
// Sequencing controller for the ASCON-128 encryption datapath.
// Inputs: clock_i, resetb_i, start_i, data_valid_i, block_i.
// Outputs: round_o, block counter controls, state/XOR strobes,
// ciphertext/tag capture strobes and the end_o completion pulse.
module fsm_ascon
    import ascon_pack::*;
#(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] block_i,
    output logic [3:0] round_o,
    output logic       en_block_o,
    output logic       init_block_o,
    output logic       sel_state_o,
    output logic       en_reg_state_o,
    output logic       xor_data_begin_o,
    output logic       xor_key_begin_o,
    output logic       xor_key_end_o,
    output logic       xor_lsb_end_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       end_o
);

    localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
    localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);

    state_t     state_q;
    state_t     state_d;
    logic       init_a;
    logic       init_b;
    logic       en_round;
    logic [3:0] round;

    compteur_double_init u_round (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .init_a_i (init_a),
        .init_b_i (init_b),
        .en_i     (en_round),
        .cnt_o    (round)
    );

    assign round_o = round;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        init_a           = 1'b0;
        init_b           = 1'b0;
        en_round         = 1'b0;
        en_block_o       = 1'b0;
        init_block_o     = 1'b0;
        sel_state_o      = 1'b0;
        en_reg_state_o   = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_lsb_end_o    = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        end_o            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    init_a       = 1'b1;
                    en_block_o   = 1'b1;
                    init_block_o = 1'b1;
                    state_d      = S_INIT;
                end
            end

            S_INIT: begin
                en_reg_state_o = 1'b1;
                en_round       = 1'b1;
                // Round 0 absorbs IV||K||N instead of the state register.
                sel_state_o    = (round != ROUND_INIT_A);
                if (round == ROUND_LAST) begin
                    xor_key_end_o = 1'b1;
                    state_d       = S_AD_WAIT;
                end
            end

            S_AD_WAIT: begin
                if (data_valid_i) begin
                    init_b  = 1'b1;
                    state_d = S_AD;
                end
            end

            S_AD: begin
                en_reg_state_o   = 1'b1;
                sel_state_o      = 1'b1;
                en_round         = 1'b1;
                xor_data_begin_o = (round == ROUND_INIT_B);
                if (round == ROUND_LAST) begin
                    en_block_o = 1'b1;
                    if (block_i == AD_LAST) begin
                        xor_lsb_end_o = 1'b1;
                        init_block_o  = 1'b1;
                        state_d       = S_PT_WAIT;
                    end else begin
                        state_d = S_AD_WAIT;
                    end
                end
            end

            S_PT_WAIT: begin
                if (data_valid_i) begin
                    // The last plaintext block is absorbed by FINAL.
                    if (block_i == PT_LAST) begin
                        init_a  = 1'b1;
                        state_d = S_FINAL;
                    end else begin
                        init_b  = 1'b1;
                        state_d = S_PT;
                    end
                end
            end

            S_PT: begin
                en_reg_state_o = 1'b1;
                sel_state_o    = 1'b1;
                en_round       = 1'b1;
                if (round == ROUND_INIT_B) begin
                    xor_data_begin_o = 1'b1;
                    en_cipher_o      = 1'b1;
                end
                if (round == ROUND_LAST) begin
                    en_block_o = 1'b1;
                    state_d    = S_PT_WAIT;
                end
            end

            S_FINAL: begin
                en_reg_state_o = 1'b1;
                sel_state_o    = 1'b1;
                en_round       = 1'b1;
                if (round == ROUND_INIT_A) begin
                    xor_data_begin_o = 1'b1;
                    xor_key_begin_o  = 1'b1;
                    en_cipher_o      = 1'b1;
                end
                if (round == ROUND_LAST) begin
                    xor_key_end_o = 1'b1;
                    en_tag_o      = 1'b1;
                    state_d       = S_DONE;
                end
            end

            S_DONE: begin
                end_o   = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_ascon.sv
// Self-checking bench for fsm_ascon: default and (3,1) block configurations.
// Compares against a schedule-based reference and a table of fixed points.
module tb_fsm_ascon;

    localparam logic [10:0] ENB = 11'h400;
    localparam logic [10:0] INB = 11'h200;
    localparam logic [10:0] SEL = 11'h100;
    localparam logic [10:0] REG = 11'h080;
    localparam logic [10:0] XD  = 11'h040;
    localparam logic [10:0] XKB = 11'h020;
    localparam logic [10:0] XKE = 11'h010;
    localparam logic [10:0] LSB = 11'h008;
    localparam logic [10:0] CIP = 11'h004;
    localparam logic [10:0] TAG = 11'h002;
    localparam logic [10:0] ENDP = 11'h001;

    typedef struct packed {
        logic        w;
        logic [3:0]  r;
        logic [10:0] s;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [3:0]  rnd;
        logic [10:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic dv = 1'b0;
    logic [3:0] blk0, blk1;

    logic [3:0] rnd0, rnd1;
    logic enb0, inb0, sel0, reg0, xd0, xkb0, xke0, lsb0, cip0, tag0, end0;
    logic enb1, inb1, sel1, reg1, xd1, xkb1, xke1, lsb1, cip1, tag1, end1;

    logic [3:0]  r_o [2];
    logic [10:0] s_o [2];

    int n_cmp = 0;
    int n_fail = 0;

    ent_t sch [2][256];
    int   slen [2];
    bit   m_idle [2];
    int   m_pos [2];
    logic [3:0] m_last [2];

    always #5 clk = ~clk;

    fsm_ascon u_dut0 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start),
        .data_valid_i(dv), .block_i(blk0), .round_o(rnd0),
        .en_block_o(enb0), .init_block_o(inb0), .sel_state_o(sel0),
        .en_reg_state_o(reg0), .xor_data_begin_o(xd0),
        .xor_key_begin_o(xkb0), .xor_key_end_o(xke0),
        .xor_lsb_end_o(lsb0), .en_cipher_o(cip0), .en_tag_o(tag0),
        .end_o(end0)
    );

    fsm_ascon #(.NB_AD_BLOCKS(3), .NB_PT_BLOCKS(1)) u_dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start),
        .data_valid_i(dv), .block_i(blk1), .round_o(rnd1),
        .en_block_o(enb1), .init_block_o(inb1), .sel_state_o(sel1),
        .en_reg_state_o(reg1), .xor_data_begin_o(xd1),
        .xor_key_begin_o(xkb1), .xor_key_end_o(xke1),
        .xor_lsb_end_o(lsb1), .en_cipher_o(cip1), .en_tag_o(tag1),
        .end_o(end1)
    );

    assign r_o[0] = rnd0;
    assign r_o[1] = rnd1;
    assign s_o[0] = {enb0, inb0, sel0, reg0, xd0, xkb0, xke0, lsb0, cip0, tag0, end0};
    assign s_o[1] = {enb1, inb1, sel1, reg1, xd1, xkb1, xke1, lsb1, cip1, tag1, end1};

    // External block counters, as the datapath would hold them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) blk0 <= 4'd0;
        else if (enb0) blk0 <= inb0 ? 4'd0 : blk0 + 4'd1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) blk1 <= 4'd0;
        else if (enb1) blk1 <= inb1 ? 4'd0 : blk1 + 4'd1;
    end

    task automatic push(input int k, input logic w, input int r, input logic [10:0] s);
        sch[k][slen[k]] = '{w: w, r: 4'(r), s: s};
        slen[k]++;
    endtask

    // Whole-run schedule: each entry is one cycle, or a WAIT gated by dv.
    task automatic build(input int k, input int nad, input int npt);
        slen[k] = 0;
        for (int r = 0; r < 12; r++)
            push(k, 0, r, REG | (r != 0 ? SEL : 11'h0) | (r == 11 ? XKE : 11'h0));
        for (int a = 0; a < nad; a++) begin
            push(k, 1, 0, 11'h0);
            for (int r = 6; r < 12; r++)
                push(k, 0, r, REG | SEL | (r == 6 ? XD : 11'h0)
                     | (r == 11 ? (ENB | (a == nad - 1 ? (LSB | INB) : 11'h0)) : 11'h0));
        end
        for (int p = 0; p < npt - 1; p++) begin
            push(k, 1, 0, 11'h0);
            for (int r = 6; r < 12; r++)
                push(k, 0, r, REG | SEL | (r == 6 ? (XD | CIP) : 11'h0)
                     | (r == 11 ? ENB : 11'h0));
        end
        push(k, 1, 0, 11'h0);
        for (int r = 0; r < 12; r++)
            push(k, 0, r, REG | SEL | (r == 0 ? (XD | XKB | CIP) : 11'h0)
                 | (r == 11 ? (XKE | TAG) : 11'h0));
        push(k, 0, 11, ENDP);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idle[k] = 1'b1;
            m_pos[k] = 0;
            m_last[k] = 4'd0;
        end
    endtask

    function automatic bit in_wait(input int k);
        return !m_idle[k] && sch[k][m_pos[k]].w;
    endfunction

    task automatic expect_of(input int k, output logic [3:0] r, output logic [10:0] s);
        if (m_idle[k]) begin
            r = m_last[k];
            s = start ? (ENB | INB) : 11'h0;
        end else if (sch[k][m_pos[k]].w) begin
            r = m_last[k];
            s = 11'h0;
        end else begin
            r = sch[k][m_pos[k]].r;
            s = sch[k][m_pos[k]].s;
        end
    endtask

    task automatic check_models(input int cyc);
        logic [3:0] r;
        logic [10:0] s;
        for (int k = 0; k < 2; k++) begin
            expect_of(k, r, s);
            n_cmp++;
            if (r_o[k] !== r || s_o[k] !== s) begin
                n_fail++;
                $display("FAIL model inst%0d cyc %0d: got rnd=%0d st=%b, want rnd=%0d st=%b",
                         k, cyc, r_o[k], s_o[k], r, s);
            end
        end
    endtask

    task automatic advance();
        logic [3:0] r;
        logic [10:0] s;
        for (int k = 0; k < 2; k++) begin
            expect_of(k, r, s);
            m_last[k] = r;
            if (m_idle[k]) begin
                if (start) begin
                    m_idle[k] = 1'b0;
                    m_pos[k] = 0;
                end
            end else if (sch[k][m_pos[k]].w) begin
                if (dv) m_pos[k]++;
            end else begin
                m_pos[k]++;
                if (m_pos[k] == slen[k]) m_idle[k] = 1'b1;
            end
        end
    endtask

    task automatic cyc_drive(input logic s, input logic d, input int cyc);
        @(negedge clk);
        start = s;
        dv = d;
        #1;
        check_models(cyc);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        advance();
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (r_o[k] !== 4'd0 || s_o[k] !== 11'h0) begin
                n_fail++;
                $display("FAIL %s inst%0d: got rnd=%0d st=%b, want rnd=0 st=0",
                         name, k, r_o[k], s_o[k]);
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        start = 1'b0;
        dv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero(name);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [16];
    int   end_at, end_at2, wcnt;
    logic d;

    initial begin
        tbl[0]  = '{0,  4'd0,  ENB | INB};
        tbl[1]  = '{1,  4'd0,  REG};
        tbl[2]  = '{2,  4'd1,  REG | SEL};
        tbl[3]  = '{12, 4'd11, REG | SEL | XKE};
        tbl[4]  = '{13, 4'd11, 11'h0};
        tbl[5]  = '{14, 4'd6,  REG | SEL | XD};
        tbl[6]  = '{19, 4'd11, REG | SEL | LSB | ENB | INB};
        tbl[7]  = '{20, 4'd11, 11'h0};
        tbl[8]  = '{21, 4'd6,  REG | SEL | XD | CIP};
        tbl[9]  = '{26, 4'd11, REG | SEL | ENB};
        tbl[10] = '{28, 4'd6,  REG | SEL | XD | CIP};
        tbl[11] = '{35, 4'd6,  REG | SEL | XD | CIP};
        tbl[12] = '{42, 4'd0,  REG | SEL | XD | XKB | CIP};
        tbl[13] = '{53, 4'd11, REG | SEL | XKE | TAG};
        tbl[14] = '{54, 4'd11, ENDP};
        tbl[15] = '{55, 4'd11, 11'h0};

        build(0, 1, 4);
        build(1, 3, 1);
        model_reset();
        do_reset("reset_state");

        // Nominal run with fixed checkpoints on the default instance.
        for (int c = 0; c < 56; c++) begin
            cyc_drive(c == 0, 1'b1, c);
            for (int i = 0; i < 16; i++) begin
                if (tbl[i].cyc == c) begin
                    n_cmp++;
                    if (r_o[0] !== tbl[i].rnd || s_o[0] !== tbl[i].st) begin
                        n_fail++;
                        $display("FAIL table cyc %0d: got rnd=%0d st=%b, want rnd=%0d st=%b",
                                 c, r_o[0], s_o[0], tbl[i].rnd, tbl[i].st);
                    end
                end
            end
            cyc_end();
        end

        // Five idle cycles in each WAIT state of the default instance.
        end_at = -1;
        wcnt = 0;
        for (int c = 0; c < 90; c++) begin
            if (in_wait(0)) begin
                d = (wcnt == 5);
                wcnt++;
            end else begin
                d = 1'b1;
                wcnt = 0;
            end
            cyc_drive(c == 0, d, c);
            if (end0 === 1'b1 && end_at < 0) end_at = c;
            cyc_end();
        end
        check_int("end_with_waits", end_at, 79);

        // start_i held high, dv toggling outside WAIT: back-to-back runs.
        end_at = -1;
        end_at2 = -1;
        for (int c = 0; c < 115; c++) begin
            d = in_wait(0) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc_drive(1'b1, d, c);
            if (end0 === 1'b1) begin
                if (end_at < 0) end_at = c;
                else if (end_at2 < 0) end_at2 = c;
            end
            cyc_end();
        end
        check_int("end_run1_held", end_at, 54);
        check_int("end_run2_held", end_at2, 109);
        for (int c = 0; c < 60; c++) begin
            cyc_drive(1'b0, 1'b1, c);
            cyc_end();
        end

        // Reset mid-AD at round 8, then a clean restart.
        for (int c = 0; c < 16; c++) begin
            cyc_drive(c == 0, 1'b1, c);
            cyc_end();
        end
        cyc_drive(1'b0, 1'b1, 16);
        check_int("ad_round_before_reset", int'(rnd0), 8);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        end_at = -1;
        for (int c = 0; c < 60; c++) begin
            cyc_drive(c == 0, 1'b1, c);
            if (end0 === 1'b1 && end_at < 0) end_at = c;
            cyc_end();
        end
        check_int("end_after_reset", end_at, 54);

        // Random start/dv traffic against the schedule model.
        for (int c = 0; c < 1500; c++) begin
            cyc_drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), c);
            cyc_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
